// File: rtl/ins_loader.sv
// ins_loader
// ----------
// Writes a program image into the instruction memory of the single-cycle
// MIPS core and keeps the core out of run until the whole image has been
// written and its checksum has matched.
//
// Frame on the byte stream:
//   CNT_HI, CNT_LO   16-bit big-endian word count N
//   N x 4 bytes      instruction words, most significant byte first
//   CSUM             XOR of every preceding frame byte (count bytes included)
//
// Handshake: a byte moves when RX_Valid && RX_Ready are both high at a rising
// edge of CLK. RX_Valid may drop for any number of cycles; the loader holds
// its state. RX_Ready is low in IDLE, WRITE, DONE and ERR, so each word costs
// one extra cycle for its write strobe.
//
// Ports
//   CLK        clock, rising edge
//   RST        synchronous reset, active low
//   START      one-cycle pulse; starts a load from IDLE, DONE or ERR
//   RX_Data    stream byte
//   RX_Valid   RX_Data is valid
//   RX_Ready   loader can take a byte this cycle
//   WE         instruction-memory write strobe, one cycle per word
//   W_Addr     word address of the write (holds afterwards)
//   W_Ins      instruction word of the write (holds afterwards)
//   CPU_RUN    core run enable, high only in DONE
//   BUSY       high while a load is in progress
//   DONE       load completed and checksum matched
//   ERR        load aborted (count too large or checksum mismatch)
//   dbg_state  current state encoding, for observation only

module ins_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [7:0]        RX_Data,
    input  logic              RX_Valid,
    output logic              RX_Ready,
    output logic              WE,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [31:0]       W_Ins,
    output logic              CPU_RUN,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [2:0]        dbg_state
);

    localparam int          DEPTH   = 1 << ADDR_W;
    localparam logic [16:0] DEPTH_V = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_HI = 3'd1,
        S_CNT_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CSUM   = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t state_q, state_d;

    logic [15:0]       cnt_q;
    // One bit wider than the address so N = DEPTH can be reached without
    // wrapping before the end-of-image compare.
    logic [ADDR_W:0]   word_idx_q;
    logic [1:0]        byte_idx_q;
    logic [7:0]        xor_q;
    logic [23:0]       shift_q;
    logic [ADDR_W-1:0] w_addr_q;
    logic [31:0]       w_ins_q;

    logic              rx_ready;
    logic              we;
    logic              busy;
    logic              accept;
    logic              start_load;
    logic [15:0]       cnt_full;
    logic [ADDR_W:0]   word_idx_next;

    assign accept        = RX_Valid && rx_ready;
    // Full count as it becomes known while the low byte is being accepted.
    assign cnt_full      = {cnt_q[15:8], RX_Data};
    assign word_idx_next = word_idx_q + 1'b1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rx_ready   = 1'b0;
        we         = 1'b0;
        busy       = 1'b1;
        start_load = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                busy = 1'b0;
                if (START) begin
                    start_load = 1'b1;
                    state_d    = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                rx_ready = 1'b1;
                if (RX_Valid) begin
                    state_d = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                rx_ready = 1'b1;
                if (RX_Valid) begin
                    if ({1'b0, cnt_full} > DEPTH_V) begin
                        state_d = S_ERR;
                    end else if (cnt_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (RX_Valid && byte_idx_q == 2'd3) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                we = 1'b1;
                if (17'(word_idx_next) == {1'b0, cnt_q}) begin
                    state_d = S_CSUM;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CSUM: begin
                rx_ready = 1'b1;
                if (RX_Valid) begin
                    state_d = (RX_Data == xor_q) ? S_DONE : S_ERR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: count, byte assembly, running XOR, write address/data
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            xor_q      <= '0;
            shift_q    <= '0;
            w_addr_q   <= '0;
            w_ins_q    <= '0;
        end else begin
            if (start_load) begin
                word_idx_q <= '0;
                byte_idx_q <= '0;
                xor_q      <= '0;
            end

            // The checksum byte itself is not folded into the running XOR.
            if (accept && state_q != S_CSUM) begin
                xor_q <= xor_q ^ RX_Data;
            end

            case (state_q)
                S_CNT_HI: begin
                    if (accept) begin
                        cnt_q[15:8] <= RX_Data;
                    end
                end
                S_CNT_LO: begin
                    if (accept) begin
                        cnt_q[7:0] <= RX_Data;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        if (byte_idx_q == 2'd3) begin
                            // Latch address and word together so both hold
                            // steady through and after the write strobe.
                            w_ins_q    <= {shift_q, RX_Data};
                            w_addr_q   <= word_idx_q[ADDR_W-1:0];
                            byte_idx_q <= '0;
                        end else begin
                            shift_q    <= {shift_q[15:0], RX_Data};
                            byte_idx_q <= byte_idx_q + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    word_idx_q <= word_idx_next;
                end
                default: begin
                end
            endcase
        end
    end

    assign RX_Ready  = rx_ready;
    assign WE        = we;
    assign W_Addr    = w_addr_q;
    assign W_Ins     = w_ins_q;
    assign BUSY      = busy;
    assign DONE      = (state_q == S_DONE);
    assign CPU_RUN   = (state_q == S_DONE);
    assign ERR       = (state_q == S_ERR);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ins_loader.sv
// Bench for ins_loader: directed frames from the block's description plus
// random frames, each checked against a frame-level model that parses the
// byte list and predicts the writes and the final DONE/ERR outcome.

module tb_ins_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int W      = ADDR_W + 32;

    logic              clk;
    logic              rst;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              we;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_ins;
    logic              cpu_run;
    logic              busy;
    logic              done;
    logic              err;
    logic [2:0]        dbg_state;

    ins_loader #(.ADDR_W(ADDR_W)) dut (
        .CLK      (clk),
        .RST      (rst),
        .START    (start),
        .RX_Data  (rx_data),
        .RX_Valid (rx_valid),
        .RX_Ready (rx_ready),
        .WE       (we),
        .W_Addr   (w_addr),
        .W_Ins    (w_ins),
        .CPU_RUN  (cpu_run),
        .BUSY     (busy),
        .DONE     (done),
        .ERR      (err),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] wr_q[$];
    logic [7:0]   frame[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic         exp_done;
    logic         exp_err;
    int           n_send;

    // Every write strobe is recorded mid-cycle; a strobe lasting two cycles
    // shows up as a duplicate entry.
    always @(negedge clk) begin
        if (we) wr_q.push_back({w_addr, w_ins});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_ready_timeout observed=0 expected=1");
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    // ---------------- frame builders ----------------
    task automatic frame_begin(input int n);
        frame.delete();
        frame.push_back(8'(n >> 8));
        frame.push_back(8'(n));
    endtask

    task automatic push_word(input logic [31:0] w);
        frame.push_back(w[31:24]);
        frame.push_back(w[23:16]);
        frame.push_back(w[15:8]);
        frame.push_back(w[7:0]);
    endtask

    task automatic frame_end(input logic corrupt);
        logic [7:0] x;
        x = 8'h00;
        foreach (frame[i]) x = x ^ frame[i];
        if (corrupt) x = x ^ 8'(1 << $urandom_range(0, 7));
        frame.push_back(x);
    endtask

    // ---------------- reference model ----------------
    // Reads the frame as the stream format defines it and predicts the
    // sequence of (address, word) writes and the final outcome.
    task automatic model();
        int         n;
        logic [7:0] x;
        logic [31:0] w;
        exp_q.delete();
        n = (int'(frame[0]) << 8) | int'(frame[1]);
        if (n > DEPTH) begin
            n_send   = 2;
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        n_send = frame.size();
        for (int k = 0; k < n; k++) begin
            w = {frame[2+4*k], frame[3+4*k], frame[4+4*k], frame[5+4*k]};
            exp_q.push_back({ADDR_W'(k), w});
        end
        x = 8'h00;
        for (int i = 0; i < frame.size() - 1; i++) x = x ^ frame[i];
        exp_done = (x == frame[frame.size()-1]);
        exp_err  = !exp_done;
    endtask

    // mode 0: back-to-back bytes, 1: one idle cycle between bytes,
    // 2: random gaps. START is pulsed again before byte busy_at (if >= 0).
    task automatic run_frame(input string tag, input int mode, input int busy_at);
        int gap;
        model();
        wr_q.delete();
        pulse_start();
        chk({tag, "_ready_after_start"}, 64'(rx_ready), 64'd1);
        chk({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        for (int i = 0; i < n_send; i++) begin
            if (i == busy_at) pulse_start();
            gap = (mode == 0) ? 0 : (mode == 1) ? 1 : $urandom_range(0, 3);
            send_byte(frame[i], gap);
        end
        chk({tag, "_done"}, 64'(done), 64'(exp_done));
        chk({tag, "_err"}, 64'(err), 64'(exp_err));
        chk({tag, "_cpu_run"}, 64'(cpu_run), 64'(exp_done));
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        chk({tag, "_ready_end"}, 64'(rx_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_n_writes"}, 64'(wr_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            if (wr_q[i] !== exp_q[i] || i < 4 || i == exp_q.size() - 1)
                chk({tag, "_write"}, 64'(wr_q[i]), 64'(exp_q[i]));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_ready", 64'(rx_ready), 64'd0);
        chk("rst_outs", 64'({w_addr, w_ins, cpu_run, busy, done, err}), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of the first word discards the partial frame.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("midrst_ready", 64'(rx_ready), 64'd0);
        chk("midrst_outs", 64'({we, w_addr, w_ins, cpu_run, busy, done, err}), 64'd0);
        @(posedge clk); #1;
        chk("midrst_no_write", 64'(wr_q.size()), 64'd0);

        // Single word, correct checksum.
        frame = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
        run_frame("one_word", 0, -1);

        // Three words with RX_Valid toggling.
        frame_begin(3);
        push_word(32'h8C010000);
        push_word(32'h00221820);
        push_word(32'hAC030004);
        frame_end(1'b0);
        run_frame("three_words", 1, -1);

        // Empty images.
        frame = '{8'h00, 8'h00, 8'h00};
        run_frame("empty_ok", 0, -1);
        frame = '{8'h00, 8'h00, 8'h5A};
        run_frame("empty_bad", 0, -1);

        // Count one above capacity: ERR right after the count.
        frame = '{8'h01, 8'h01};
        run_frame("overflow", 0, -1);

        // Full capacity image.
        frame_begin(DEPTH);
        for (int k = 0; k < DEPTH; k++) push_word($urandom);
        frame_end(1'b0);
        run_frame("full_depth", 0, -1);

        // Bad checksum after one written word; the write still happens.
        frame = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
        run_frame("bad_csum", 0, -1);

        // START while busy must not disturb the load.
        frame_begin(2);
        push_word(32'h12345678);
        push_word(32'h9ABCDEF0);
        frame_end(1'b0);
        run_frame("busy_start", 2, 5);

        // Random frames.
        for (int r = 0; r < 8; r++) begin
            frame_begin($urandom_range(0, 6));
            for (int k = 0; k < ((int'(frame[0]) << 8) | int'(frame[1])); k++)
                push_word($urandom);
            frame_end($urandom_range(0, 3) == 0);
            run_frame("random", $urandom_range(0, 2), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so a stuck handshake can never hang the run.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ins_loader.md
# ins_loader

Instruction loader that writes a program image into the instruction memory of the single-cycle MIPS core. It is the writer side of the core's instruction-write port (WE, W_Ins). It accepts a framed byte stream over a valid/ready interface, assembles big-endian 32-bit words, and issues one write strobe per word. The core is held out of run until a complete, checksum-verified image has been written.

## Interface
- ADDR_W, 8: instruction-memory word-address width; capacity DEPTH = 2^ADDR_W words.
- CLK  in  1  single clock; all state changes on its rising edge.
- RST  in  1  reset, synchronous, active-low.
- START  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR; ignored while BUSY.
- RX_Data  in  8  stream byte.
- RX_Valid  in  1  RX_Data is valid.
- RX_Ready  out  1  loader accepts a byte; a transfer occurs when RX_Valid && RX_Ready.
- WE  out  1  instruction-memory write strobe, exactly one cycle per word.
- W_Addr  out  ADDR_W  word address for the current write.
- W_Ins  out  32  instruction word for the current write.
- CPU_RUN  out  1  high only in DONE; drives the core's run enable.
- BUSY  out  1  high in every state except IDLE, DONE and ERR.
- DONE  out  1  load completed and checksum matched.
- ERR  out  1  load aborted (length overflow or checksum mismatch).

## Operation
- Frame format: CNT_HI, CNT_LO (16-bit big-endian word count N), then N×4 data bytes (each word MSB first), then one CSUM byte. CSUM equals the XOR of all preceding frame bytes, including the count bytes.
- States: IDLE, CNT_HI, CNT_LO, DATA, WRITE, CSUM, DONE, ERR.
- IDLE/DONE/ERR + START → CNT_HI. On this transition: clear word index, byte index, running XOR, DONE and ERR.
- CNT_HI: accept a byte → CNT_LO.
- CNT_LO: accept a byte, then evaluate N:
  - N > DEPTH → ERR.
  - N = 0 → CSUM.
  - otherwise → DATA.
- DATA: accept bytes and shift them into a 32-bit word register. After the 4th byte → WRITE.
- WRITE: WE=1 for one cycle, with W_Addr = word index and W_Ins = the assembled word.
  - Word index increments.
  - If the word index now equals N → CSUM; otherwise → DATA with byte index reset.
- CSUM: accept a byte.
  - Byte equals running XOR → DONE.
  - Otherwise → ERR.
- Running XOR is updated on every accepted byte except the CSUM byte itself.
- RX_Ready = 1 in CNT_HI, CNT_LO, DATA and CSUM; 0 in IDLE, WRITE, DONE and ERR. No byte is consumed in WRITE, so backpressure is one cycle per word.
- Words already written before an ERR stay in memory. CPU_RUN remains 0 in ERR.
- A START pulse in DONE drops CPU_RUN and begins a reload.

## Timing
- Reset (RST=0 at a clock edge): state IDLE; WE, W_Addr, W_Ins, RX_Ready, CPU_RUN, BUSY, DONE and ERR all 0. Reset overrides everything, including mid-frame; a partial frame is discarded.
- START sampled high in IDLE → RX_Ready=1 on the next cycle.
- WE rises the cycle after the 4th byte of a word is accepted and lasts exactly one cycle. W_Addr and W_Ins are valid in that same cycle and hold afterwards.
- Minimum frame duration: 2 + 5N + 1 cycles at full RX_Valid rate.
- DONE, ERR and CPU_RUN are registered. They assert the cycle after the CSUM byte is accepted (ERR: the cycle after CNT_LO for an overflow).
- RX_Valid gaps of any length are tolerated in any receiving state; the state is held.
- N = DEPTH is legal: the last write is at W_Addr = DEPTH-1, and the index must not wrap before the compare.

## Test plan
- Reset mid-DATA after 2 bytes → all outputs 0, state IDLE; the next full frame loads correctly from W_Addr 0.
- Frame 00 01 20 08 00 05 2C → a single WE pulse with W_Addr=0, W_Ins=0x20080005; then DONE=1, CPU_RUN=1, ERR=0.
- Frame of 3 words 0x8C010000, 0x00221820, 0xAC030004 with correct CSUM, RX_Valid toggling every other cycle → WE at W_Addr 0, 1, 2 with matching words; DONE=1.
- Frame 00 00 00 → no WE; DONE=1. Frame 00 00 5A → ERR=1, CPU_RUN=0.
- With ADDR_W=8, count 0x0101 → ERR the cycle after CNT_LO, no WE. Count 0x0100 with correct data → last write at W_Addr=0xFF, then DONE.
- Frame 00 01 20 08 00 05 2D → WE once, then ERR=1, CPU_RUN=0. START pulse while BUSY → ignored, load unaffected.
